// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// State encoding and PC source mux select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StRun   = 2'd1,
        StHalt  = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] PC_SRC_VEC = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;
    localparam logic [1:0] PC_SRC_SEQ = 2'b11;

endpackage

// File: rtl/ctrl_seq_counter.sv
// Saturating up-counter that times the post-reset flush window.
// Asynchronously cleared by rst_n, synchronously cleared by clr.
module ctrl_seq_counter #(
    parameter int unsigned MAX_COUNT = 2,
    parameter int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < WIDTH'(MAX_COUNT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: start-up flush, redirect, load-use stall and halt/resume sequencing.
// Optional trap redirect enabled by defining PIPE_CTRL_TRAP_EN.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned                NUM_STAGES         = 5,
    parameter int unsigned                RESET_FLUSH_CYCLES = 2,
    parameter logic [NUM_STAGES-1:0]      REDIRECT_MASK      = 5'b00011
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  branch_taken_in,
    input  logic                  jump_in,
    input  logic                  load_use_in,
    input  logic                  halt_in,
    input  logic                  resume_in,
`ifdef PIPE_CTRL_TRAP_EN
    input  logic                  trap_in,
    output logic                  vector_sel_out,
    output logic                  epc_we_out,
`endif
    output logic [NUM_STAGES-1:0] flush_out,
    output logic                  stall_out,
    output logic                  pc_en_out,
    output logic [1:0]            pc_src_out,
    output logic                  busy_out
);

    localparam int unsigned CntWidth = $clog2(RESET_FLUSH_CYCLES + 1);
    // Load-use bubble is inserted into the EX pipeline register.
    localparam logic [NUM_STAGES-1:0] LoadUseMask = NUM_STAGES'(1) << 2;

    ctrl_state_e         state_q;
    ctrl_state_e         state_d;
    logic [CntWidth-1:0] cnt;
    logic                flush_done;

    ctrl_seq_counter #(
        .MAX_COUNT (RESET_FLUSH_CYCLES),
        .WIDTH     (CntWidth)
    ) u_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .clr   (state_q != StReset),
        .en    (state_q == StReset),
        .count (cnt)
    );

    assign flush_done = (cnt == CntWidth'(RESET_FLUSH_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = StReset;
        flush_out  = '1;
        stall_out  = 1'b0;
        pc_en_out  = 1'b1;
        pc_src_out = PC_SRC_VEC;
        busy_out   = 1'b0;
`ifdef PIPE_CTRL_TRAP_EN
        vector_sel_out = 1'b0;
        epc_we_out     = 1'b0;
`endif
        unique case (state_q)
            StReset: begin
                busy_out = 1'b1;
                state_d  = flush_done ? StRun : StReset;
            end
            StRun: begin
                state_d = halt_in ? StHalt : StRun;
                if (jump_in) begin
                    pc_src_out = PC_SRC_JMP;
                    flush_out  = REDIRECT_MASK;
                end else if (branch_taken_in) begin
                    pc_src_out = PC_SRC_BR;
                    flush_out  = REDIRECT_MASK;
                end else if (load_use_in) begin
                    pc_src_out = PC_SRC_SEQ;
                    pc_en_out  = 1'b0;
                    stall_out  = 1'b1;
                    flush_out  = LoadUseMask;
                end else begin
                    pc_src_out = PC_SRC_SEQ;
                    flush_out  = '0;
                end
            end
            StHalt: begin
                pc_src_out = PC_SRC_SEQ;
                pc_en_out  = 1'b0;
                stall_out  = 1'b1;
                flush_out  = '0;
                state_d    = resume_in ? StRun : StHalt;
            end
            default: begin
                state_d = StReset;
            end
        endcase
`ifdef PIPE_CTRL_TRAP_EN
        // Trap outranks every other request once the core is running.
        if (trap_in && (state_q == StRun || state_q == StHalt)) begin
            pc_src_out     = PC_SRC_VEC;
            vector_sel_out = 1'b1;
            flush_out      = '1;
            epc_we_out     = 1'b1;
            pc_en_out      = 1'b1;
            stall_out      = 1'b0;
            state_d        = StRun;
        end
`endif
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit; trap scenario runs when PIPE_CTRL_TRAP_EN is defined.
// Output vector compared as {flush[4:0], stall, pc_en, pc_src[1:0], busy}.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch_taken, jump, load_use, halt, resume;
    logic [4:0] flush, flush1;
    logic       stall, pc_en, busy, stall1, pc_en1, busy1;
    logic [1:0] pc_src, pc_src1;
`ifdef PIPE_CTRL_TRAP_EN
    logic       trap;
    logic       vector_sel, epc_we, vector_sel1, epc_we1;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .branch_taken_in (branch_taken),
        .jump_in         (jump),
        .load_use_in     (load_use),
        .halt_in         (halt),
        .resume_in       (resume),
`ifdef PIPE_CTRL_TRAP_EN
        .trap_in         (trap),
        .vector_sel_out  (vector_sel),
        .epc_we_out      (epc_we),
`endif
        .flush_out       (flush),
        .stall_out       (stall),
        .pc_en_out       (pc_en),
        .pc_src_out      (pc_src),
        .busy_out        (busy)
    );

    pipe_ctrl_unit #(.RESET_FLUSH_CYCLES(1)) dut1 (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .branch_taken_in (branch_taken),
        .jump_in         (jump),
        .load_use_in     (load_use),
        .halt_in         (halt),
        .resume_in       (resume),
`ifdef PIPE_CTRL_TRAP_EN
        .trap_in         (trap),
        .vector_sel_out  (vector_sel1),
        .epc_we_out      (epc_we1),
`endif
        .flush_out       (flush1),
        .stall_out       (stall1),
        .pc_en_out       (pc_en1),
        .pc_src_out      (pc_src1),
        .busy_out        (busy1)
    );

    localparam logic [9:0] ExpReset = {5'b11111, 1'b0, 1'b1, 2'b00, 1'b1};
    localparam logic [9:0] ExpSeq   = {5'b00000, 1'b0, 1'b1, 2'b11, 1'b0};
    localparam logic [9:0] ExpBr    = {5'b00011, 1'b0, 1'b1, 2'b01, 1'b0};
    localparam logic [9:0] ExpJmp   = {5'b00011, 1'b0, 1'b1, 2'b10, 1'b0};
    localparam logic [9:0] ExpLu    = {5'b00100, 1'b1, 1'b0, 2'b11, 1'b0};
    localparam logic [9:0] ExpHalt  = {5'b00000, 1'b1, 1'b0, 2'b11, 1'b0};

    logic [9:0] obs;
    logic [9:0] obs1;

    always_comb obs  = {flush, stall, pc_en, pc_src, busy};
    always_comb obs1 = {flush1, stall1, pc_en1, pc_src1, busy1};

    task automatic clear_inputs();
        branch_taken = 1'b0;
        jump         = 1'b0;
        load_use     = 1'b0;
        halt         = 1'b0;
        resume       = 1'b0;
`ifdef PIPE_CTRL_TRAP_EN
        trap         = 1'b0;
`endif
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) step();
        #1;
        tests_run++;
        if (obs !== ExpReset) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b want %b", obs, ExpReset);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpReset) begin
            tests_failed++;
            $display("FAIL reset_release_cyc0: got %b want %b", obs, ExpReset);
        end
        tests_run++;
        if (obs1 !== ExpReset) begin
            tests_failed++;
            $display("FAIL rfc1_cyc0: got %b want %b", obs1, ExpReset);
        end
        step(); #1;
        tests_run++;
        if (obs !== ExpReset) begin
            tests_failed++;
            $display("FAIL reset_flush_edge1: got %b want %b", obs, ExpReset);
        end
        tests_run++;
        if (obs1 !== ExpSeq) begin
            tests_failed++;
            $display("FAIL rfc1_run_after_1: got %b want %b", obs1, ExpSeq);
        end
        step(); #1;
        tests_run++;
        if (obs !== ExpSeq) begin
            tests_failed++;
            $display("FAIL run_after_2: got %b want %b", obs, ExpSeq);
        end
    endtask

    task automatic test_branch();
        step();
        branch_taken = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpBr) begin
            tests_failed++;
            $display("FAIL branch_cycle: got %b want %b", obs, ExpBr);
        end
        step();
        branch_taken = 1'b0;
        #1;
        tests_run++;
        if (obs !== ExpSeq) begin
            tests_failed++;
            $display("FAIL branch_after: got %b want %b", obs, ExpSeq);
        end
    endtask

    task automatic test_hazards();
        step();
        load_use = 1'b1;
        jump     = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpJmp) begin
            tests_failed++;
            $display("FAIL jump_over_load_use: got %b want %b", obs, ExpJmp);
        end
        step();
        jump         = 1'b0;
        branch_taken = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpBr) begin
            tests_failed++;
            $display("FAIL branch_over_load_use: got %b want %b", obs, ExpBr);
        end
        step();
        branch_taken = 1'b0;
        jump         = 1'b1;
        branch_taken = 1'b1;
        load_use     = 1'b0;
        #1;
        tests_run++;
        if (obs !== ExpJmp) begin
            tests_failed++;
            $display("FAIL jump_over_branch: got %b want %b", obs, ExpJmp);
        end
        step();
        clear_inputs();
        load_use = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpLu) begin
            tests_failed++;
            $display("FAIL load_use_alone: got %b want %b", obs, ExpLu);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_halt();
        step();
        halt = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpSeq) begin
            tests_failed++;
            $display("FAIL halt_req_cycle: got %b want %b", obs, ExpSeq);
        end
        step();
        halt         = 1'b0;
        branch_taken = 1'b1;
        load_use     = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpHalt) begin
            tests_failed++;
            $display("FAIL halt_ignores_inputs: got %b want %b", obs, ExpHalt);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (obs !== ExpHalt) begin
            tests_failed++;
            $display("FAIL halt_held: got %b want %b", obs, ExpHalt);
        end
        step();
        halt   = 1'b1;
        resume = 1'b1;
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (obs !== ExpSeq) begin
            tests_failed++;
            $display("FAIL resume_wins: got %b want %b", obs, ExpSeq);
        end
        // Redirect in the halt-request cycle still takes effect.
        step();
        halt = 1'b1;
        jump = 1'b1;
        #1;
        tests_run++;
        if (obs !== ExpJmp) begin
            tests_failed++;
            $display("FAIL halt_with_jump: got %b want %b", obs, ExpJmp);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (obs !== ExpHalt) begin
            tests_failed++;
            $display("FAIL halt_after_jump: got %b want %b", obs, ExpHalt);
        end
    endtask

    task automatic test_async_reset_in_halt();
        // Still in HALT from the previous task.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== ExpReset) begin
            tests_failed++;
            $display("FAIL async_reset_from_halt: got %b want %b", obs, ExpReset);
        end
        step();
        rst_n = 1'b1;
        step(); step(); #1;
        tests_run++;
        if (obs !== ExpSeq) begin
            tests_failed++;
            $display("FAIL run_after_rereset: got %b want %b", obs, ExpSeq);
        end
    endtask

`ifdef PIPE_CTRL_TRAP_EN
    task automatic test_trap();
        step();
        trap = 1'b1;
        jump = 1'b1;
        #1;
        tests_run++;
        if ({obs, vector_sel, epc_we} !== {5'b11111, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL trap_over_jump: got %b %b %b want 1111101000 1 1",
                     obs, vector_sel, epc_we);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if ({obs, vector_sel, epc_we} !== {ExpSeq, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL trap_after: got %b %b %b want %b 0 0",
                     obs, vector_sel, epc_we, ExpSeq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_hazards();
        test_halt();
        test_async_reset_in_halt();
`ifdef PIPE_CTRL_TRAP_EN
        test_trap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
